// File: rtl/fetch_refill_ctrl.sv
// Fetch miss handler: turns one fetch miss into an uncached single-beat read or a 16-word
// line refill. Optional macro FETCH_REFILL_CRITICAL_WORD_FIRST_EN starts the burst at the missed word.
`default_nettype none

module fetch_refill_ctrl #(
    parameter int LINE_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [31:0] miss_addr,
    input  logic        miss_uncached,

    output logic        mem_ar_valid,
    input  logic        mem_ar_ready,
    output logic [31:0] mem_ar_addr,
    output logic [3:0]  mem_ar_len,
    output logic        mem_ar_wrap,

    input  logic        mem_r_valid,
    output logic        mem_r_ready,
    input  logic [31:0] mem_r_data,
    input  logic        mem_r_err,
    input  logic        mem_r_last,

    output logic        uncached_we,
    output logic [31:0] uncached_addr,
    output logic [35:0] uncached_din,

    output logic        refilled_reset,
    output logic        refilled_wea,
    output logic [31:0] refilled_addra,
    output logic        refilled_web,
    output logic [3:0]  refilled_addrb,
    output logic [35:0] refilled_dinb,

    input  logic        snoop_hit,
    input  logic [31:0] snoop_addr,

    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_AREQ  = 2'd2;
    localparam logic [1:0] S_DATA  = 2'd3;

    localparam logic [3:0] LINE_LAST = 4'(LINE_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_unc_q, req_unc_d;
    logic        kill_q, kill_d;
    logic [3:0]  beat_q, beat_d;

    logic        unc_we_q, unc_we_d;
    logic [31:0] unc_addr_q, unc_addr_d;
    logic [35:0] unc_din_q, unc_din_d;
    logic        web_q, web_d;
    logic [3:0]  addrb_q, addrb_d;
    logic [35:0] dinb_q, dinb_d;

    logic [3:0]  start_idx;
    logic        wrap_en;
    logic        is_line;
    logic        in_xfer;
    logic        snoop_match;
    logic        kill_now;
    logic        beat_acc;
    logic        last_beat;
    logic        ar_fire;
    logic [35:0] beat_word;
    logic [31:0] unc_word_addr;

`ifdef FETCH_REFILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = req_addr_q[5:2];
    assign wrap_en   = 1'b1;
`else
    assign start_idx = 4'd0;
    assign wrap_en   = 1'b0;
`endif

    assign is_line       = ~req_unc_q;
    assign in_xfer       = (state_q == S_AREQ) || (state_q == S_DATA);
    assign snoop_match   = snoop_hit && is_line && in_xfer &&
                           (snoop_addr[12:6] == req_addr_q[12:6]);
    // A snoop in the current cycle already blocks this cycle's writes, not just later ones.
    assign kill_now      = kill_q | snoop_match;
    assign beat_acc      = (state_q == S_DATA) && mem_r_valid;
    assign last_beat     = beat_acc && (beat_q == (req_unc_q ? 4'd0 : LINE_LAST));
    assign ar_fire       = (state_q == S_AREQ) && mem_ar_ready;
    assign beat_word     = {mem_r_err, 3'b000, mem_r_data};
    assign unc_word_addr = {req_addr_q[31:2], 2'b00};

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        req_unc_d  = req_unc_q;
        beat_d     = beat_q;

        case (state_q)
            S_IDLE: begin
                if (miss_valid) begin
                    req_addr_d = miss_addr;
                    req_unc_d  = miss_uncached;
                    state_d    = miss_uncached ? S_AREQ : S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_AREQ;
            S_AREQ: begin
                if (mem_ar_ready) begin
                    state_d = S_DATA;
                    beat_d  = 4'd0;
                end
            end
            S_DATA: begin
                if (beat_acc) begin
                    beat_d = beat_q + 4'd1;
                end
                // mem_r_last is deliberately ignored; the beat counter decides the end.
                if (last_beat) begin
                    state_d = S_IDLE;
                    beat_d  = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        kill_d = (state_d == S_IDLE) ? 1'b0 : kill_now;

        unc_we_d   = beat_acc && req_unc_q;
        unc_addr_d = unc_we_d ? unc_word_addr : 32'd0;
        unc_din_d  = unc_we_d ? beat_word : 36'd0;

        web_d      = beat_acc && is_line && !kill_now;
        addrb_d    = web_d ? (start_idx + beat_q) : 4'd0;
        dinb_d     = web_d ? beat_word : 36'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_addr_q <= 32'd0;
            req_unc_q  <= 1'b0;
            kill_q     <= 1'b0;
            beat_q     <= 4'd0;
            unc_we_q   <= 1'b0;
            unc_addr_q <= 32'd0;
            unc_din_q  <= 36'd0;
            web_q      <= 1'b0;
            addrb_q    <= 4'd0;
            dinb_q     <= 36'd0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            req_unc_q  <= req_unc_d;
            kill_q     <= kill_d;
            beat_q     <= beat_d;
            unc_we_q   <= unc_we_d;
            unc_addr_q <= unc_addr_d;
            unc_din_q  <= unc_din_d;
            web_q      <= web_d;
            addrb_q    <= addrb_d;
            dinb_q     <= dinb_d;
        end
    end

    assign miss_ready     = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign refilled_reset = (state_q == S_CLEAR);

    assign mem_ar_valid   = (state_q == S_AREQ);
    assign mem_ar_addr    = (state_q != S_AREQ) ? 32'd0 :
                            req_unc_q ? unc_word_addr :
                                        {req_addr_q[31:6], start_idx, 2'b00};
    assign mem_ar_len     = ((state_q == S_AREQ) && is_line) ? LINE_LAST : 4'd0;
    assign mem_ar_wrap    = (state_q == S_AREQ) && is_line && wrap_en;

    // Tag write rides the AR handshake; CLEAR has already emptied the buffer.
    assign refilled_wea   = ar_fire && is_line && !kill_now;
    assign refilled_addra = refilled_wea ? req_addr_q : 32'd0;

    assign mem_r_ready    = (state_q == S_DATA);

    assign uncached_we    = unc_we_q;
    assign uncached_addr  = unc_addr_q;
    assign uncached_din   = unc_din_q;
    assign refilled_web   = web_q;
    assign refilled_addrb = addrb_q;
    assign refilled_dinb  = dinb_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_r_last};

endmodule

`default_nettype wire
